// File: rtl/multi_input_adder_stream_if.sv
// Stream bundle for multi_input_adder_stream: lane beats in, frame sums out.
// The slave side is the adder, the master side is whoever drives the lanes
// and consumes the results.
interface multi_input_adder_stream_if #(
  parameter int NUM_INPUT = 8,
  parameter int WIDTH_IN  = 16,
  parameter int WIDTH_OUT = 19
);
  logic                               i_valid;
  logic                               o_ready;
  logic [NUM_INPUT-1:0][WIDTH_IN-1:0] i_data;
  logic                               i_last;
  logic                               o_valid;
  logic                               i_ready;
  logic [WIDTH_OUT-1:0]               o_data;
  logic                               o_overflow;

  modport slave (
    input  i_valid, i_data, i_last, i_ready,
    output o_ready, o_valid, o_data, o_overflow
  );

  modport master (
    output i_valid, i_data, i_last, i_ready,
    input  o_ready, o_valid, o_data, o_overflow
  );
endinterface

// File: rtl/multi_input_adder_stream.sv
// Streaming lane adder: a balanced adder tree with optional register levels,
// followed by a frame accumulator and an output register with saturate/wrap.
// One global clock enable stalls the whole pipe under backpressure, so no beat
// is ever lost or duplicated.
module multi_input_adder_stream #(
  parameter int NUM_INPUT   = 8,
  parameter int WIDTH_IN    = 16,
  parameter int IS_SIGNED   = 1,
  parameter int PIPE_STAGES = 1,
  parameter int ACC_BEATS   = 1,
  parameter int WIDTH_OUT   = WIDTH_IN + $clog2(NUM_INPUT) + $clog2(ACC_BEATS),
  parameter int SATURATE    = 1
) (
  input logic                        i_clk,
  input logic                        i_rst_n,
  multi_input_adder_stream_if.slave  bus
);

  localparam int LEVELS = $clog2(NUM_INPUT);
  localparam int FULL   = WIDTH_IN + LEVELS + $clog2(ACC_BEATS);
  localparam int CNT_W  = (ACC_BEATS > 1) ? $clog2(ACC_BEATS) : 1;

  if (WIDTH_IN <= 0) begin : g_chk_width_in
    $error("multi_input_adder_stream: WIDTH_IN must be positive");
  end
  if (NUM_INPUT < 2) begin : g_chk_num_input
    $error("multi_input_adder_stream: NUM_INPUT must be at least 2");
  end
  if (ACC_BEATS < 1) begin : g_chk_acc_beats
    $error("multi_input_adder_stream: ACC_BEATS must be at least 1");
  end
  if (PIPE_STAGES > LEVELS) begin : g_chk_pipe
    $error("multi_input_adder_stream: PIPE_STAGES exceeds tree depth");
  end
  if (WIDTH_OUT < WIDTH_IN) begin : g_chk_width_out
    $error("multi_input_adder_stream: WIDTH_OUT below WIDTH_IN");
  end

  logic ce;
  logic [FULL-1:0] lvl_data [LEVELS+1][NUM_INPUT];
  logic            lvl_valid [LEVELS+1];
  logic            lvl_last  [LEVELS+1];

  // Everything advances together; reset forces ready low combinationally.
  assign ce          = bus.i_ready | ~bus.o_valid;
  assign bus.o_ready = ce & i_rst_n;

  for (genvar j = 0; j < NUM_INPUT; j++) begin : g_lane
    assign lvl_data[0][j] = {{(FULL-WIDTH_IN){(IS_SIGNED != 0) & bus.i_data[j][WIDTH_IN-1]}},
                             bus.i_data[j]};
  end
  assign lvl_valid[0] = bus.i_valid & bus.o_ready;
  assign lvl_last[0]  = bus.i_last;

  // Level k halves the node count; a register follows level k whenever the
  // running share k*PIPE_STAGES/LEVELS crosses an integer, which spreads the
  // stages evenly and always lands the last one on the final level.
  for (genvar k = 1; k <= LEVELS; k++) begin : g_level
    localparam int N_PREV   = (NUM_INPUT + (1 << (k - 1)) - 1) >> (k - 1);
    localparam int N_CUR    = (N_PREV + 1) / 2;
    localparam bit REG_HERE = ((k * PIPE_STAGES) / LEVELS) != (((k - 1) * PIPE_STAGES) / LEVELS);

    logic [FULL-1:0] sum_c      [N_CUR];
    logic [FULL-1:0] stage_data [N_CUR];
    logic            stage_valid;
    logic            stage_last;

    for (genvar j = 0; j < N_CUR; j++) begin : g_node
      if (2 * j + 1 < N_PREV) begin : g_pair
        assign sum_c[j] = lvl_data[k-1][2*j] + lvl_data[k-1][2*j+1];
      end else begin : g_pass
        assign sum_c[j] = lvl_data[k-1][2*j];
      end
    end

    if (REG_HERE) begin : g_reg
      // Pipeline register for this level, data plus valid/last sideband.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          for (int j = 0; j < N_CUR; j++) stage_data[j] <= '0;
          stage_valid <= 1'b0;
          stage_last  <= 1'b0;
        end else if (ce) begin
          stage_data  <= sum_c;
          stage_valid <= lvl_valid[k-1];
          stage_last  <= lvl_last[k-1];
        end
      end
    end else begin : g_comb
      assign stage_data  = sum_c;
      assign stage_valid = lvl_valid[k-1];
      assign stage_last  = lvl_last[k-1];
    end

    for (genvar j = 0; j < NUM_INPUT; j++) begin : g_out
      if (j < N_CUR) begin : g_used
        assign lvl_data[k][j] = stage_data[j];
      end else begin : g_unused
        assign lvl_data[k][j] = '0;
      end
    end
    assign lvl_valid[k] = stage_valid;
    assign lvl_last[k]  = stage_last;
  end

  logic [FULL-1:0]      tree_out;
  logic                 tree_valid;
  logic                 tree_last;
  logic [FULL-1:0]      acc;
  logic [FULL-1:0]      acc_base;
  logic [FULL-1:0]      sum_s;
  logic [CNT_W-1:0]     cnt;
  logic                 close;
  logic [WIDTH_OUT-1:0] conv_data;
  logic                 conv_ovf;

  assign tree_out   = lvl_data[LEVELS][0];
  assign tree_valid = lvl_valid[LEVELS];
  assign tree_last  = lvl_last[LEVELS];

  // The first beat of a frame starts from zero rather than the stale acc.
  assign acc_base = (cnt == '0) ? '0 : acc;
  assign sum_s    = acc_base + tree_out;
  assign close    = tree_valid & ((cnt == CNT_W'(ACC_BEATS - 1)) | tree_last);

  if (WIDTH_OUT >= FULL) begin : g_wide
    logic ext_bit;
    assign ext_bit   = (IS_SIGNED != 0) & sum_s[FULL-1];
    assign conv_data = WIDTH_OUT'($signed({ext_bit, sum_s}));
    assign conv_ovf  = 1'b0;
  end else begin : g_narrow
    logic                 in_range;
    logic [WIDTH_OUT-1:0] sat_val;
    if (IS_SIGNED != 0) begin : g_signed
      assign in_range = (&sum_s[FULL-1:WIDTH_OUT-1]) | ~(|sum_s[FULL-1:WIDTH_OUT-1]);
      assign sat_val  = sum_s[FULL-1] ? {1'b1, {(WIDTH_OUT-1){1'b0}}}
                                      : {1'b0, {(WIDTH_OUT-1){1'b1}}};
    end else begin : g_unsigned
      assign in_range = ~(|sum_s[FULL-1:WIDTH_OUT]);
      assign sat_val  = '1;
    end
    assign conv_data = ((SATURATE != 0) && !in_range) ? sat_val : sum_s[WIDTH_OUT-1:0];
    assign conv_ovf  = ~in_range;
  end

  // Frame accumulator: keep partial sums until the count or i_last closes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (ce && tree_valid) begin
      if (close) begin
        cnt <= '0;
      end else begin
        acc <= sum_s;
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Output register: load on frame close, otherwise the result is consumed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_data     <= '0;
      bus.o_valid    <= 1'b0;
      bus.o_overflow <= 1'b0;
    end else if (ce) begin
      if (close) begin
        bus.o_data     <= conv_data;
        bus.o_valid    <= 1'b1;
        bus.o_overflow <= conv_ovf;
      end else begin
        bus.o_valid    <= 1'b0;
        bus.o_overflow <= 1'b0;
      end
    end
  end

endmodule

// File: doc/multi_input_adder_stream.md
Name: multi_input_adder_stream

Overview:
- Streaming successor to the team's pipelined adder tree.
- Sums NUM_INPUT lanes per beat through a balanced adder tree with a configurable number of register stages.
- Optionally accumulates ACC_BEATS consecutive beats into one result, or fewer if i_last closes the frame early.
- Has a valid/ready handshake with full backpressure and configurable output width with saturate or wrap.
- Sits between DSP lane producers (correlators, FIR taps) and downstream stream consumers.

Parameters:
- NUM_INPUT, 8: lanes summed per beat (>=2).
- WIDTH_IN, 16: bits per lane.
- IS_SIGNED, 1: 1 = two's complement, 0 = unsigned.
- PIPE_STAGES, 1: register levels inside the tree. 0 = combinational tree. Must be <= $clog2(NUM_INPUT).
- ACC_BEATS, 1: beats accumulated per output (>=1).
- WIDTH_OUT, WIDTH_IN+$clog2(NUM_INPUT)+$clog2(ACC_BEATS): output width, must be >= WIDTH_IN.
- SATURATE, 1: when WIDTH_OUT is below full precision, 1 = clip to min/max, 0 = keep low bits.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  input beat valid.
- o_ready  out  1  block accepts a beat this cycle.
- i_data  in  [NUM_INPUT] x WIDTH_IN  lane values.
- i_last  in  1  beat closes the current accumulation frame early.
- o_valid  out  1  o_data holds a result.
- i_ready  in  1  downstream accepts the result.
- o_data  out  WIDTH_OUT  frame sum.
- o_overflow  out  1  frame sum not representable in WIDTH_OUT; qualified by o_valid.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - While i_rst_n is low: all stage valid bits, last flags, accumulator, beat counter, o_data, o_valid and o_overflow are 0.
  - o_ready is forced low while i_rst_n is low.
  - Reset asserted mid-frame discards the partial sum with no output. The first beat after release starts a new frame.
- Internal precision: FULL = WIDTH_IN+$clog2(NUM_INPUT)+$clog2(ACC_BEATS).
  - Each lane is sign- or zero-extended to FULL per IS_SIGNED before level 0.
  - No intermediate overflow is possible.
- Tree: $clog2(NUM_INPUT) adder levels.
  - PIPE_STAGES registers are placed after levels spread evenly (ceil grouping), the last register at the final level.
  - An odd node count passes the unpaired node through to the next level.
- Sideband: each tree register stage carries a valid bit and a last bit alongside its data.
- Global advance: ce = i_ready OR NOT o_valid; o_ready = ce (when out of reset).
  - All pipeline registers, the accumulator and the output register update only when ce = 1.
  - When ce = 0 everything holds: o_data and o_valid stay stable and no beat is lost or duplicated.
- Accept: a beat is accepted when i_valid AND o_ready. A non-accepted cycle inserts a bubble (valid 0) that does not touch the accumulator.
- Accumulator stage (one register, always present), on a tree-output beat with valid = 1 and ce = 1:
  - The running sum is S = (cnt==0 ? 0 : acc) + tree.
  - If cnt == ACC_BEATS-1 or the beat's last = 1: the output register loads S, o_valid goes to 1 next cycle, and cnt returns to 0.
  - Otherwise: acc <= S and cnt increments.
- Output register:
  - When ce = 1 and no frame closes this cycle, o_valid drops to 0 (result consumed).
  - Back-to-back frames sustain one result per accepted close, i.e. full throughput.
- Latency: the closing beat's result appears PIPE_STAGES+1 cycles after it is accepted, absent stalls.
  - Each stall cycle adds exactly one cycle.
- ACC_BEATS = 1: every beat produces an output; i_last is ignored.
- Width conversion (S is FULL bits):
  - WIDTH_OUT >= FULL: sign-/zero-extend S; o_overflow = 0.
  - WIDTH_OUT < FULL, SATURATE = 1: clip S to the signed or unsigned WIDTH_OUT range; o_overflow = 1 when clipping occurred.
  - WIDTH_OUT < FULL, SATURATE = 0: o_data = S[WIDTH_OUT-1:0]; o_overflow = 1 when S is out of range.
- Elaboration checks: $error for WIDTH_IN <= 0, NUM_INPUT < 2, ACC_BEATS < 1, PIPE_STAGES > $clog2(NUM_INPUT), WIDTH_OUT < WIDTH_IN.

Test Plan:
1. NUM_INPUT=8, WIDTH_IN=16, signed, PIPE_STAGES=2, ACC_BEATS=1, i_ready=1. All lanes 0x7FFF for one beat -> o_valid pulses 3 cycles after accept with o_data=19'h3FFF8 (262136), o_overflow=0. All lanes 0x8000 -> o_data=19'h40000 (-262144).
2. Same config with ACC_BEATS=4, lanes 1..8 (beat sum 36). Four consecutive beats -> single o_valid with o_data=144. Next frame with i_last on beat 2 -> o_data=72, then a following 4-beat frame -> 144.
3. Backpressure: stream 10 beats of distinct sums with i_ready=0 for 5 cycles while o_valid=1 -> o_data stable, o_ready=0, no input accepted. On release, all outputs arrive in order with none lost or repeated.
4. Bubbles: i_valid toggling 1,0,1,0 with ACC_BEATS=2, beat sums 10 and 20 -> one output 30; bubbles do not advance cnt.
5. Narrow output: WIDTH_OUT=16, SATURATE=1, all lanes 0x7FFF -> o_data=16'h7FFF, o_overflow=1. With SATURATE=0 -> o_data=16'hFFF8, o_overflow=1. With all lanes 0x0001 -> o_data=8, o_overflow=0.
6. Reset mid-frame: ACC_BEATS=4, pull i_rst_n low after 2 beats -> o_valid=0 and o_ready=0 immediately without waiting for a clock. After release, 4 beats of sum 36 -> o_data=144, not 216.
